// File: rtl/nor_bank.sv
// Bank of registered NOR channels: negedge sampling, posedge pipeline of
// configurable depth, and sticky per-channel oscillation detection on y.

module nor_bank_lane #(
    parameter int OSC_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic toggle,
    input  logic osc_clr,
    output logic osc
);
    localparam logic [7:0] LIMIT = 8'(OSC_LIMIT);

    logic [7:0] tc;
    logic [7:0] tc_next;
    logic       set;

    always_comb begin
        tc_next = 8'd0;
        if (toggle) tc_next = (tc >= LIMIT) ? LIMIT : tc + 8'd1;
    end

    // Reaching the limit on a toggling edge sets the flag, including when the
    // counter is already saturated, so a cleared flag re-arms on the next toggle.
    assign set = adv && toggle && (tc_next == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc  <= 8'd0;
            osc <= 1'b0;
        end else begin
            if (adv) tc <= tc_next;
            if (set) osc <= 1'b1;
            else if (osc_clr) osc <= 1'b0;
        end
    end
endmodule

module nor_bank #(
    parameter int               WIDTH     = 8,
    parameter int               FANIN     = 4,
    parameter int               LATENCY   = 1,
    parameter logic [WIDTH-1:0] IV        = {WIDTH{1'b0}},
    parameter int               OSC_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*FANIN-1:0] in,
    input  logic                   hold,
    input  logic                   osc_clr,
    output logic [WIDTH-1:0]       y,
    output logic [WIDTH-1:0]       osc
);
    if (WIDTH < 1 || WIDTH > 64 || FANIN < 1 || FANIN > 16 ||
        LATENCY < 1 || LATENCY > 8 || OSC_LIMIT < 2 || OSC_LIMIT > 255) begin : g_bad_param
        $error("nor_bank: parameter out of legal range");
    end

    logic [WIDTH-1:0]              nor_now;
    logic [WIDTH-1:0]              s;
    logic [WIDTH-1:0]              y_next;
    logic [WIDTH-1:0]              toggle;
    logic [LATENCY-1:0][WIDTH-1:0] stage;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign nor_now[i] = ~|in[i*FANIN +: FANIN];

        nor_bank_lane #(.OSC_LIMIT(OSC_LIMIT)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (!hold),
            .toggle  (toggle[i]),
            .osc_clr (osc_clr),
            .osc     (osc[i])
        );
    end

    // Sample half a cycle ahead of the shift; hold deliberately does not gate it.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) s <= IV;
        else        s <= nor_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {LATENCY{IV}};
        end else if (!hold) begin
            stage[0] <= s;
            for (int j = 1; j < LATENCY; j++) stage[j] <= stage[j-1];
        end
    end

    // Value y takes on the next shift, used to detect a toggle before it lands.
    if (LATENCY == 1) begin : g_lat1
        assign y_next = s;
    end else begin : g_latn
        assign y_next = stage[LATENCY-2];
    end

    assign y      = stage[LATENCY-1];
    assign toggle = y_next ^ y;
endmodule
